nrisc_control_fsm: RTL and testbench
====================================

Name: nrisc_control_fsm

Overview:
- Multicycle control unit for the 8-bit nRISC core.
- Drives the ALU operation code (ULA_Control) and the datapath enables (PC, IR, register file, memory).
- Consumes the ALU COND output: latches it on SLT and uses the stored flag for the conditional branch.
- Sits between the instruction register and the datapath. Interacts with memory through a ready handshake.

Parameters:
- OPCODE_W, 4, width of the opcode field, IR[7:4].
- RESET_PC_SRC, 2'b00, pc_src value driven while in reset and idle states.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  IR[7:4]; stable from DECODE until the instruction completes.
- cond_in  in  1  COND output of the ALU.
- mem_ready  in  1  memory access done this cycle.
- ula_control  out  2  ALU operation: 00 ADD, 01 SUB, 10 SLT, 11 NOT.
- ula_src_b  out  1  ALU B operand select: 0 register, 1 sign-extended immediate.
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  update PC this cycle.
- pc_src  out  2  PC source: 00 PC+1, 01 branch target, 10 jump target.
- reg_write  out  1  register file write enable.
- wb_src  out  2  writeback source: 00 ALU Resultado, 01 memory data, 10 immediate.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- cond_flag  out  1  stored SLT result.
- halted  out  1  core stopped.
- illegal  out  1  undefined opcode seen (see Optional Feature).

Behaviour:
- Reset: rst_n low forces state FETCH and cond_flag=0 immediately, including mid-instruction or mid-memory-wait.
  - Output values while reset is held: mem_read=1. All other outputs are 0, including ula_control=00 and pc_src=RESET_PC_SRC.
- Outputs are combinational decodes of (state, opcode, cond_flag). cond_flag is the only registered datapath-visible output.
- Opcodes: 0000 ADD, 0001 SUB, 0010 SLT, 0011 NOT, 0100 LW, 0101 SW, 0110 BC (branch if cond_flag), 0111 J, 1000 LI, 1111 HALT. All others are undefined.
- FETCH: mem_read=1. When mem_ready=1: ir_write=1, go to DECODE. Otherwise remain in FETCH.
- DECODE: one cycle, no enables asserted. Next state by opcode:
  - ALU ops -> EXEC
  - LW/SW -> MEM
  - BC -> BRANCH
  - J -> JUMP
  - LI -> LI_WB
  - HALT -> HALT
- EXEC: ula_control from the low 2 opcode bits, ula_src_b=0.
  - SLT: cond_flag <= cond_in; pc_write=1, pc_src=00; go to FETCH. No register write.
  - ADD/SUB/NOT: go to ALU_WB.
- ALU_WB: ula_control held, reg_write=1, wb_src=00, pc_write=1, pc_src=00; go to FETCH.
- MEM: ula_control=00, ula_src_b=1 (address = base + immediate). mem_read=1 for LW, mem_write=1 for SW; held until mem_ready.
  - LW with ready: go to LW_WB.
  - SW with ready: pc_write=1, pc_src=00; go to FETCH.
- LW_WB: reg_write=1, wb_src=01, pc_write=1, pc_src=00; go to FETCH.
- BRANCH: pc_write=1, pc_src = cond_flag ? 01 : 00; go to FETCH. cond_flag is unchanged; it changes only on SLT or reset.
- JUMP: pc_write=1, pc_src=10; go to FETCH.
- LI_WB: reg_write=1, wb_src=10, pc_write=1, pc_src=00; go to FETCH.
- HALT: halted=1, all enables 0. Terminal until reset.
- Latency with mem_ready always 1:
  - 4 cycles: ADD, SUB, NOT, LW.
  - 3 cycles: SLT, SW, BC, J, LI.
  - Each cycle mem_ready is low in FETCH or MEM adds one cycle.
- mem_read and mem_write are never asserted together. pc_write is asserted exactly once per completed instruction.

Optional Feature:
- Macro: NRISC_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE goes to HALT; illegal=1 and halted=1 until reset.
- Undefined: an undefined opcode executes as a NOP (DECODE -> JUMP-like state with pc_src=00, pc_write=1); illegal is tied 0.

Decomposition:
- Shared package nrisc_pkg holds:
  - opcode localparams (OP_ADD … OP_HALT);
  - ULA_Control codes (ULA_ADD=00, ULA_SUB=01, ULA_SLT=10, ULA_NOT=11);
  - pc_src and wb_src encodings;
  - the state enum.
- One combinational sub-module, nrisc_op_decode, maps opcode to (instruction class, ula_control). It is reused by the FSM and by the bench scoreboard.

Test Plan:
- Reset mid-MEM wait: assert rst_n=0 during SW with mem_ready=0 -> state FETCH immediately, mem_write=0, cond_flag=0.
- ADD, mem_ready=1: opcode 0000 -> ula_control=00 in EXEC and ALU_WB, one reg_write pulse with wb_src=00, one pc_write, 4 cycles total.
- SLT then BC: SLT with cond_in=1 -> cond_flag=1. Next BC -> pc_src=01. Repeat with cond_in=0 -> pc_src=00.
- LW with memory wait: mem_ready low for 3 cycles in MEM -> mem_read held, ula_control=00, ula_src_b=1. Then LW_WB with wb_src=01; 7 cycles total.
- HALT: opcode 1111 -> halted=1, no further pc_write or mem_read for 20 cycles. rst_n pulse returns to FETCH.
- Undefined opcode 1010:
  - NRISC_ILLEGAL_TRAP_EN defined -> illegal=1, halted=1.
  - NRISC_ILLEGAL_TRAP_EN undefined -> pc_write with pc_src=00, execution continues.

Source files
------------

// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared definitions for the nRISC multicycle control unit.
//   - opcode encodings (IR[7:4])
//   - ULA_Control codes, pc_src and wb_src encodings
//   - FSM state enum and decoded instruction class
package nrisc_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_NOT  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BC   = 4'b0110;
    localparam logic [3:0] OP_J    = 4'b0111;
    localparam logic [3:0] OP_LI   = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] ULA_ADD = 2'b00;
    localparam logic [1:0] ULA_SUB = 2'b01;
    localparam logic [1:0] ULA_SLT = 2'b10;
    localparam logic [1:0] ULA_NOT = 2'b11;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM, S_LW_WB,
        S_BRANCH, S_JUMP, S_LI_WB, S_HALT, S_NOP, S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU, CL_MEM, CL_BC, CL_J, CL_LI, CL_HALT, CL_ILL
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic [1:0] ula;
    } dec_t;

endpackage

// File: rtl/nrisc_control_fsm_if.sv
// nrisc_control_fsm_if: control-unit <-> datapath/memory signal bundle.
//   master: the control FSM (drives enables, ULA_Control, flags)
//   slave : datapath side (drives opcode, ALU COND, memory ready)
interface nrisc_control_fsm_if #(parameter int OPCODE_W = 4);
    logic [OPCODE_W-1:0] opcode;
    logic                cond_in;
    logic                mem_ready;
    logic [1:0]          ula_control;
    logic                ula_src_b;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic                reg_write;
    logic [1:0]          wb_src;
    logic                mem_read;
    logic                mem_write;
    logic                cond_flag;
    logic                halted;
    logic                illegal;

    modport master (
        input  opcode, cond_in, mem_ready,
        output ula_control, ula_src_b, ir_write, pc_write, pc_src, reg_write,
               wb_src, mem_read, mem_write, cond_flag, halted, illegal
    );

    modport slave (
        output opcode, cond_in, mem_ready,
        input  ula_control, ula_src_b, ir_write, pc_write, pc_src, reg_write,
               wb_src, mem_read, mem_write, cond_flag, halted, illegal
    );
endinterface

// File: rtl/nrisc_op_decode.sv
// nrisc_op_decode: combinational opcode classifier.
//   opcode : IR[7:4]
//   dec    : instruction class + ULA_Control (low two opcode bits)
module nrisc_op_decode
    import nrisc_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output dec_t                dec
);

    always_comb begin
        dec.cls = CL_ILL;
        dec.ula = opcode[1:0];
        case (opcode)
            OP_ADD, OP_SUB, OP_SLT, OP_NOT: dec.cls = CL_ALU;
            OP_LW, OP_SW:                   dec.cls = CL_MEM;
            OP_BC:                          dec.cls = CL_BC;
            OP_J:                           dec.cls = CL_J;
            OP_LI:                          dec.cls = CL_LI;
            OP_HALT:                        dec.cls = CL_HALT;
            default:                        dec.cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/nrisc_control_fsm.sv
// nrisc_control_fsm: multicycle control unit for the 8-bit nRISC core.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : nrisc_control_fsm_if.master (opcode/cond_in/mem_ready in,
//                ALU control, datapath enables, cond_flag, halted, illegal out)
// Build option: NRISC_ILLEGAL_TRAP_EN -- undefined opcodes trap to a halted
// state with illegal=1; otherwise they retire as a NOP (PC+1).
module nrisc_control_fsm
    import nrisc_pkg::*;
#(
    parameter int         OPCODE_W     = 4,
    parameter logic [1:0] RESET_PC_SRC = 2'b00
) (
    input  logic                clk,
    input  logic                rst_n,
    nrisc_control_fsm_if.master bus
);

    state_e state, state_nx;
    dec_t   dec;
    logic   cond_q;
    logic   is_slt;

    nrisc_op_decode #(.OPCODE_W(OPCODE_W)) u_dec (
        .opcode (bus.opcode),
        .dec    (dec)
    );

    assign is_slt = (dec.cls == CL_ALU) && (dec.ula == ULA_SLT);

    // State register and the SLT flag; the flag only moves on SLT in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            cond_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_EXEC && is_slt)
                cond_q <= bus.cond_in;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (bus.mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (dec.cls)
                    CL_ALU:  state_nx = S_EXEC;
                    CL_MEM:  state_nx = S_MEM;
                    CL_BC:   state_nx = S_BRANCH;
                    CL_J:    state_nx = S_JUMP;
                    CL_LI:   state_nx = S_LI_WB;
                    CL_HALT: state_nx = S_HALT;
`ifdef NRISC_ILLEGAL_TRAP_EN
                    default: state_nx = S_TRAP;
`else
                    default: state_nx = S_NOP;
`endif
                endcase
            end
            S_EXEC:   state_nx = is_slt ? S_FETCH : S_ALU_WB;
            S_MEM: begin
                if (bus.mem_ready)
                    state_nx = (bus.opcode == OP_LW) ? S_LW_WB : S_FETCH;
            end
            S_ALU_WB, S_LW_WB, S_BRANCH, S_JUMP, S_LI_WB, S_NOP:
                      state_nx = S_FETCH;
            S_HALT, S_TRAP: state_nx = state;
            default:  state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        bus.ula_control = ULA_ADD;
        bus.ula_src_b   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = RESET_PC_SRC;
        bus.reg_write   = 1'b0;
        bus.wb_src      = WB_ALU;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.halted      = 1'b0;
        bus.illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                // Gated so an IR load cannot sneak through while reset is held.
                bus.ir_write = bus.mem_ready && rst_n;
            end
            S_EXEC: begin
                bus.ula_control = dec.ula;
                if (is_slt) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_NEXT;
                end
            end
            S_ALU_WB: begin
                bus.ula_control = dec.ula;
                bus.reg_write   = 1'b1;
                bus.wb_src      = WB_ALU;
                bus.pc_write    = 1'b1;
                bus.pc_src      = PC_NEXT;
            end
            S_MEM: begin
                bus.ula_src_b = 1'b1;
                if (bus.opcode == OP_LW) begin
                    bus.mem_read = 1'b1;
                end else begin
                    bus.mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = PC_NEXT;
                    end
                end
            end
            S_LW_WB, S_LI_WB: begin
                bus.reg_write = 1'b1;
                bus.wb_src    = (state == S_LW_WB) ? WB_MEM : WB_IMM;
                bus.pc_write  = 1'b1;
                bus.pc_src    = PC_NEXT;
            end
            S_BRANCH: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = cond_q ? PC_BRANCH : PC_NEXT;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PC_JUMP;
            end
            S_NOP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PC_NEXT;
            end
            S_HALT: bus.halted = 1'b1;
            S_TRAP: begin
                bus.halted  = 1'b1;
                bus.illegal = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cond_flag = cond_q;

endmodule

// File: tb/tb_nrisc_control_fsm.sv
module tb_nrisc_control_fsm;

    typedef struct packed {
        logic [1:0] ula;
        logic       srcb, irw, pcw;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] wb;
        logic       mr, mw, cf, hlt, ill;
    } outs_t;

    typedef struct {
        logic [3:0] op;
        logic       ci, rdy;
        outs_t      exp;
        string      nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    nrisc_control_fsm_if #(.OPCODE_W(4)) bus ();

    nrisc_control_fsm #(.OPCODE_W(4), .RESET_PC_SRC(2'b00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic outs_t e(input logic [1:0] ula, input logic srcb, irw, pcw,
                                input logic [1:0] pcs, input logic rw,
                                input logic [1:0] wb, input logic mr, mw, cf, hlt, ill);
        outs_t o;
        o = '{ula, srcb, irw, pcw, pcs, rw, wb, mr, mw, cf, hlt, ill};
        return o;
    endfunction

    // Expected output patterns per control step.
    function automatic outs_t f_(input logic rdy, cf);      return e(2'b00,0,rdy,0,2'b00,0,2'b00,1,0,cf,0,0); endfunction
    function automatic outs_t dc(input logic cf);           return e(2'b00,0,0,0,2'b00,0,2'b00,0,0,cf,0,0); endfunction
    function automatic outs_t ex(input logic [1:0] u, input logic pcw, cf);
                                                            return e(u,0,0,pcw,2'b00,0,2'b00,0,0,cf,0,0); endfunction
    function automatic outs_t wbk(input logic [1:0] u, w, input logic cf);
                                                            return e(u,0,0,1,2'b00,1,w,0,0,cf,0,0); endfunction
    function automatic outs_t mm(input logic lw, pcw, cf);  return e(2'b00,1,0,pcw,2'b00,0,2'b00,lw,!lw,cf,0,0); endfunction
    function automatic outs_t br(input logic [1:0] p, input logic cf);
                                                            return e(2'b00,0,0,1,p,0,2'b00,0,0,cf,0,0); endfunction
    function automatic outs_t hl(input logic il, cf);       return e(2'b00,0,0,0,2'b00,0,2'b00,0,0,cf,1,il); endfunction

    function automatic outs_t sample();
        outs_t o;
        o = '{bus.ula_control, bus.ula_src_b, bus.ir_write, bus.pc_write, bus.pc_src,
              bus.reg_write, bus.wb_src, bus.mem_read, bus.mem_write, bus.cond_flag,
              bus.halted, bus.illegal};
        return o;
    endfunction

    task automatic check(input outs_t exp, input string nm);
        outs_t act;
        act = sample();
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance one clock.
    task automatic step(input logic [3:0] op, input logic ci, rdy, input outs_t exp, input string nm);
        bus.opcode    = op;
        bus.cond_in   = ci;
        bus.mem_ready = rdy;
        @(negedge clk);
        check(exp, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] op, input logic ci, rdy, input outs_t exp, input string nm);
        vec_t v;
        v.op = op; v.ci = ci; v.rdy = rdy; v.exp = exp; v.nm = nm;
        tbl.push_back(v);
    endtask

    // Reset pulse asserted mid-cycle; outputs must go to the reset pattern at once.
    task automatic reset_pulse(input string nm);
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check(f_(0, 0), nm);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.opcode    = 4'b0000;
        bus.cond_in   = 1'b1;
        bus.mem_ready = 1'b1;
        #2;
        check(f_(0, 0), "reset_state");
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD/SUB/NOT: 4 cycles, cond_in high must not touch cond_flag
        add(4'h0,1,1,f_(1,0),"add_fetch"); add(4'h0,1,1,dc(0),"add_dec");
        add(4'h0,1,1,ex(2'b00,0,0),"add_exec"); add(4'h0,1,1,wbk(2'b00,2'b00,0),"add_wb");
        add(4'h1,1,1,f_(1,0),"sub_fetch"); add(4'h1,1,1,dc(0),"sub_dec");
        add(4'h1,1,1,ex(2'b01,0,0),"sub_exec"); add(4'h1,1,1,wbk(2'b01,2'b00,0),"sub_wb");
        add(4'h3,1,1,f_(1,0),"not_fetch"); add(4'h3,1,1,dc(0),"not_dec");
        add(4'h3,1,1,ex(2'b11,0,0),"not_exec"); add(4'h3,1,1,wbk(2'b11,2'b00,0),"not_wb");
        // SLT(1) then BC taken
        add(4'h2,1,1,f_(1,0),"slt1_fetch"); add(4'h2,1,1,dc(0),"slt1_dec");
        add(4'h2,1,1,ex(2'b10,1,0),"slt1_exec");
        add(4'h6,0,1,f_(1,1),"bc1_fetch"); add(4'h6,0,1,dc(1),"bc1_dec");
        add(4'h6,0,1,br(2'b01,1),"bc1_branch");
        // SLT(0) then BC not taken
        add(4'h2,0,1,f_(1,1),"slt0_fetch"); add(4'h2,0,1,dc(1),"slt0_dec");
        add(4'h2,0,1,ex(2'b10,1,1),"slt0_exec");
        add(4'h6,1,1,f_(1,0),"bc0_fetch"); add(4'h6,1,1,dc(0),"bc0_dec");
        add(4'h6,1,1,br(2'b00,0),"bc0_branch");
        // LW with three wait cycles in MEM: 7 cycles
        add(4'h4,1,1,f_(1,0),"lw_fetch"); add(4'h4,1,1,dc(0),"lw_dec");
        add(4'h4,1,0,mm(1,0,0),"lw_wait1"); add(4'h4,1,0,mm(1,0,0),"lw_wait2");
        add(4'h4,1,0,mm(1,0,0),"lw_wait3"); add(4'h4,1,1,mm(1,0,0),"lw_mem");
        add(4'h4,1,1,wbk(2'b00,2'b01,0),"lw_wb");
        // SW with one fetch wait
        add(4'h5,1,0,f_(0,0),"sw_fwait"); add(4'h5,1,1,f_(1,0),"sw_fetch");
        add(4'h5,1,1,dc(0),"sw_dec"); add(4'h5,1,1,mm(0,1,0),"sw_mem");
        // J and LI
        add(4'h7,1,1,f_(1,0),"j_fetch"); add(4'h7,1,1,dc(0),"j_dec");
        add(4'h7,1,1,br(2'b10,0),"j_jump");
        add(4'h8,1,1,f_(1,0),"li_fetch"); add(4'h8,1,1,dc(0),"li_dec");
        add(4'h8,1,1,wbk(2'b00,2'b10,0),"li_wb");
        add(4'h0,1,0,f_(0,0),"idle_fetch");

        foreach (tbl[i]) step(tbl[i].op, tbl[i].ci, tbl[i].rdy, tbl[i].exp, tbl[i].nm);

        // Reset in the middle of an SW memory wait, with cond_flag set beforehand
        step(4'h2,1,1,f_(1,0),"rs_slt_fetch"); step(4'h2,1,1,dc(0),"rs_slt_dec");
        step(4'h2,1,1,ex(2'b10,1,0),"rs_slt_exec");
        step(4'h5,0,1,f_(1,1),"rs_sw_fetch"); step(4'h5,0,1,dc(1),"rs_sw_dec");
        step(4'h5,0,0,mm(0,0,1),"rs_sw_wait");
        reset_pulse("rs_mid_mem");
        step(4'h5,0,0,f_(0,0),"rs_after");

        // HALT: terminal, no pc_write or mem_read for 20 cycles even with ready high
        step(4'hF,1,1,f_(1,0),"halt_fetch"); step(4'hF,1,1,dc(0),"halt_dec");
        for (int i = 0; i < 20; i++) step(4'hF,1,1,hl(0,0),"halt_hold");
        reset_pulse("halt_reset");
        step(4'hF,1,1,f_(1,0),"halt_refetch");

        // Undefined opcode 1010
        step(4'hA,1,1,dc(0),"ill_dec");
`ifdef NRISC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) step(4'hA,1,1,hl(1,0),"ill_trap");
        reset_pulse("ill_reset");
`else
        step(4'hA,1,1,br(2'b00,0),"ill_nop");
        step(4'h0,1,1,f_(1,0),"ill_next_fetch"); step(4'h0,1,1,dc(0),"ill_next_dec");
        step(4'h0,1,1,ex(2'b00,0,0),"ill_next_exec");
        step(4'h0,1,1,wbk(2'b00,2'b00,0),"ill_next_wb");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
